// File: rtl/pixel_frame_scheduler.sv
// pixel_frame_scheduler: streams one stored frame from pixel BRAM to the
// pixel-over-UART sender in acknowledged chunks, retransmitting unacked chunks.
// Ports: clk, reset (sync, active-low); frame_req / chunk_ack pulses in;
// rd_addr out / rd_data in (BRAM, 1-cycle read latency); pix_data/pix_valid
// out with pix_ready in (sender handshake); busy, frame_done, timeout_err out.
// Option: define FRAME_HEADER_EN to send an all-ones header pixel first.
module pixel_frame_scheduler #(
    parameter int IMAGE_W      = 320,
    parameter int IMAGE_H      = 240,
    parameter int ADDR_W       = 17,
    parameter int PIXEL_W      = 12,
    parameter int CHUNK_PIXELS = 64,
    parameter int ACK_TIMEOUT  = 5000000,
    parameter int MAX_RETRIES  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_req,
    input  logic               chunk_ack,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [PIXEL_W-1:0] rd_data,
    output logic [PIXEL_W-1:0] pix_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               busy,
    output logic               frame_done,
    output logic               timeout_err
);
    localparam int NPIX = IMAGE_W * IMAGE_H;
    localparam int CW   = $clog2(CHUNK_PIXELS + 1);
    localparam int TW   = $clog2(ACK_TIMEOUT + 1);
    localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_PRESENT, S_WAIT, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic [PIXEL_W-1:0] pix_q, pix_d;
    logic               last_q, last_d;
    logic               hdr_q, hdr_d;
    logic               terr_q, terr_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            retry_q <= '0;
            pix_q   <= '0;
            last_q  <= 1'b0;
            hdr_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            pix_q   <= pix_d;
            last_q  <= last_d;
            hdr_q   <= hdr_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        timer_d = '0;
        retry_d = retry_q;
        pix_d   = pix_q;
        last_d  = last_q;
        hdr_d   = hdr_q;
        terr_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (frame_req) begin
                    addr_d  = '0;
                    base_d  = '0;
                    retry_d = '0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
`ifdef FRAME_HEADER_EN
                    // Header goes straight to PRESENT: no BRAM read needed.
                    hdr_d   = 1'b1;
                    pix_d   = '1;
                    state_d = S_PRESENT;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                pix_d   = rd_data;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (pix_ready) begin
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        cnt_d  = cnt_q + CW'(1);
                        if (addr_q == LAST) last_d = 1'b1;
                        if (cnt_q == CW'(CHUNK_PIXELS - 1) || addr_q == LAST)
                            state_d = S_WAIT;
                        else
                            state_d = S_FETCH;
                    end
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                // Ack takes priority over a coincident timeout.
                if (chunk_ack) begin
                    retry_d = '0;
                    base_d  = addr_q;
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = last_q ? S_DONE : S_FETCH;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    timer_d = '0;
                    cnt_d   = '0;
                    if (retry_q >= RW'(MAX_RETRIES)) begin
                        terr_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        retry_d = retry_q + RW'(1);
                        addr_d  = base_q;
                        last_d  = 1'b0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_addr     = addr_q;
    assign pix_data    = pix_q;
    assign pix_valid   = (state_q == S_PRESENT);
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = (state_q == S_DONE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_pixel_frame_scheduler.sv
// tb_pixel_frame_scheduler: random/directed frames against a chunk/retry
// reference model; a negedge monitor pops expected pixels and events.
module tb_pixel_frame_scheduler;
    localparam int IW = 4, IH = 1, AW = 3, PW = 12;
    localparam int CP = 2, AT = 20, MR = 1;
    localparam int NPIX = IW * IH;

    logic clk = 1'b0, reset = 1'b0, frame_req = 1'b0, chunk_ack = 1'b0;
    logic pix_ready = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_data = '0, pix_data;
    logic pix_valid, busy, frame_done, timeout_err;
    logic [PW-1:0] mem [0:7];

    pixel_frame_scheduler #(
        .IMAGE_W(IW), .IMAGE_H(IH), .ADDR_W(AW), .PIXEL_W(PW),
        .CHUNK_PIXELS(CP), .ACK_TIMEOUT(AT), .MAX_RETRIES(MR)
    ) dut (
        .clk(clk), .reset(reset), .frame_req(frame_req),
        .chunk_ack(chunk_ack), .rd_addr(rd_addr), .rd_data(rd_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rd_data <= mem[rd_addr];

    int checks = 0, errors = 0;
    logic [PW-1:0] exp_q [$];
    int len_q [$];
    bit plan_q [$];
    int done_cnt = 0, to_cnt = 0, xfer = 0;
    int ack_delay = -1, ack_fix = 0, rdy_pct = 100, bp_left = 0;
    bit mon_en = 1'b0, hold_pend = 1'b0, done_prev = 1'b0, hdr_skip = 1'b0;
    logic [PW-1:0] hold_data = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bp_left > 0) begin
            pix_ready = 1'b0;
            if (pix_valid) bp_left--;
        end else begin
            pix_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    always @(posedge clk) begin
        #1;
        chunk_ack = 1'b0;
        if (ack_delay == 0) begin
            chunk_ack = 1'b1;
            ack_delay = -1;
        end else if (ack_delay > 0) begin
            ack_delay--;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (hold_pend) begin
                chk("hold_valid", 32'(pix_valid), 32'd1);
                chk("hold_data", 32'(pix_data), 32'(hold_data));
                hold_pend = 1'b0;
            end
            if (done_prev) chk("busy_after_done", 32'(busy), 32'd0);
            done_prev = frame_done;
            if (frame_done) done_cnt++;
            if (timeout_err) to_cnt++;
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_pixel", 32'(pix_data), 32'hDEAD);
                end else begin
                    chk("pixel", 32'(pix_data), 32'(exp_q.pop_front()));
                end
                if (hdr_skip) begin
                    hdr_skip = 1'b0;
                end else if (len_q.size() > 0) begin
                    xfer++;
                    if (xfer == len_q[0]) begin
                        void'(len_q.pop_front());
                        xfer = 0;
                        if (plan_q.pop_front())
                            ack_delay = (ack_fix > 0) ? ack_fix
                                                      : $urandom_range(1, 10);
                    end
                end
            end else if (pix_valid) begin
                hold_pend = 1'b1;
                hold_data = pix_data;
            end
        end
    end

    // Reference: per chunk, one attempt per plan bit; a missing ack retries
    // the same chunk until MR retries are spent, then the frame aborts.
    task automatic model(input logic [7:0] plan, output int ed, output int et);
        int p;
        p = 0;
        ed = 0;
        et = 0;
`ifdef FRAME_HEADER_EN
        exp_q.push_back({PW{1'b1}});
`endif
        for (int base = 0; base < NPIX; base += CP) begin
            int n, tries;
            n = (NPIX - base < CP) ? NPIX - base : CP;
            tries = 0;
            forever begin
                for (int k = 0; k < n; k++) exp_q.push_back(mem[base + k]);
                len_q.push_back(n);
                plan_q.push_back(plan[p]);
                p++;
                if (plan[p-1]) break;
                if (tries == MR) begin
                    et = 1;
                    return;
                end
                tries++;
            end
        end
        ed = 1;
    endtask

    task automatic run_frame(input logic [7:0] plan, input bit extra_req);
        int ed, et, cyc, fv;
        done_cnt = 0;
        to_cnt = 0;
        xfer = 0;
        model(plan, ed, et);
`ifdef FRAME_HEADER_EN
        hdr_skip = 1'b1;
        fv = 1;
`else
        fv = 3;
`endif
        @(posedge clk);
        #1 frame_req = 1'b1;
        @(posedge clk);
        #1 frame_req = 1'b0;
        for (int i = 1; i <= fv; i++) begin
            @(negedge clk);
            chk("first_valid_latency", 32'(pix_valid), 32'(i == fv));
        end
        cyc = 0;
        while (done_cnt + to_cnt == 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (extra_req && cyc == 15 && busy) frame_req = 1'b1;
            else frame_req = 1'b0;
        end
        frame_req = 1'b0;
        chk("frame_end_in_budget", 32'(cyc < 2000), 32'd1);
        repeat (30) @(negedge clk);
        chk("done_pulses", 32'(done_cnt), 32'(ed));
        chk("timeout_pulses", 32'(to_cnt), 32'(et));
        chk("pixels_left", 32'(exp_q.size()), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
        exp_q.delete();
        len_q.delete();
        plan_q.delete();
    endtask

    initial begin
        int cyc;
        mem[0] = 12'hF00; mem[1] = 12'h0F0; mem[2] = 12'h00F;
        mem[3] = 12'hFFF;
        for (int i = 4; i < 8; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b1;
        mon_en = 1'b1;

        ack_fix = 5;
        run_frame(8'b0000_0011, 1'b0);
        bp_left = 7;
        run_frame(8'b0000_0011, 1'b0);
        ack_fix = 0;
        run_frame(8'b0000_0110, 1'b0);
        run_frame(8'b0000_0000, 1'b0);
        run_frame(8'b0000_0011, 1'b1);

        rdy_pct = 60;
        for (int r = 0; r < 8; r++)
            run_frame(8'($urandom), r[0]);
        rdy_pct = 100;

        bp_left = 1000;
        @(posedge clk);
        #1 frame_req = 1'b1;
        @(posedge clk);
        #1 frame_req = 1'b0;
        cyc = 0;
        while (!pix_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("present_reached", 32'(pix_valid), 32'd1);
        mon_en = 1'b0;
        hold_pend = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_pix_valid", 32'(pix_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b1;
        bp_left = 0;
        ack_delay = -1;
        hdr_skip = 1'b0;
        done_prev = 1'b0;
        exp_q.delete();
        len_q.delete();
        plan_q.delete();
        mon_en = 1'b1;
        run_frame(8'b0000_0011, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
